if_prefetch: RTL and testbench

//  Instruction fetch stage with a small in-order prefetch queue. Owns the PC,

---
 rtl/if_prefetch_pkg.sv | 20 ++
 rtl/if_prefetch_if.sv | 14 +
 rtl/if_prefetch_fifo.sv | 61 ++++++
 rtl/if_prefetch.sv | 106 ++++++++++
 tb/tb_if_prefetch.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/if_prefetch_pkg.sv
// Shared types and constants for the instruction-fetch prefetch stage.
package if_prefetch_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] INST_NOP   = 32'h0000_0013;
  localparam logic [XLEN-1:0] ZERO_WORD  = 32'h0000_0000;
  localparam logic            RST_ENABLE = 1'b0;

  // One buffered fetch: instruction word plus the address it came from
  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
    return pc + XLEN'(4);
  endfunction

endpackage

// File: rtl/if_prefetch_if.sv
// Instruction bus between the fetch stage (master) and the memory side (slave).
interface if_prefetch_if;
  import if_prefetch_pkg::*;

  logic            req;
  logic [XLEN-1:0] addr;
  logic            gnt;
  logic            rvalid;
  logic [XLEN-1:0] rdata;

  modport master (output req, addr, input gnt, rvalid, rdata);
  modport slave  (input req, addr, output gnt, rvalid, rdata);

endinterface

// File: rtl/if_prefetch_fifo.sv
// Synchronous in-order FIFO of {addr, inst} entries with single-cycle flush.
module if_prefetch_fifo
  import if_prefetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_push,
  input  fetch_entry_t                   i_entry,
  input  logic                           i_pop,
  input  logic                           i_flush,
  output fetch_entry_t                   o_head,
  output logic                           o_full,
  output logic                           o_empty,
  output logic [$clog2(DEPTH):0]         o_count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  fetch_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr;
  logic [PTR_W-1:0] r_rd;
  logic [CNT_W-1:0] r_count;

  logic w_push;
  logic w_pop;

  // Pop frees a slot in the same cycle, so push into a full FIFO is legal with pop
  always_comb begin
    w_pop  = i_pop && !o_empty && !i_flush;
    w_push = i_push && !i_flush && (!o_full || w_pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + PTR_W'(1);
      if (w_pop)  r_rd <= r_rd + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_entry;
  end

  assign o_head  = r_mem[r_rd];
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/if_prefetch.sv
// Fetch stage: owns the PC, issues instruction-bus requests, buffers returned
// words in order and drops responses made stale by a redirect.
module if_prefetch
  import if_prefetch_pkg::*;
#(
  parameter int unsigned     DEPTH    = 2,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_jump_flag_i,
  input  logic [XLEN-1:0]   ex_jump_addr_i,
  input  logic              hold_i,
  if_prefetch_if.master     ibus,
  output logic              inst_valid_o,
  output logic [XLEN-1:0]   inst_o,
  output logic [XLEN-1:0]   inst_addr_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned SUM_W = CNT_W + 1;

  logic [XLEN-1:0]  r_pc;
  logic [CNT_W-1:0] r_outstanding;
  logic [CNT_W-1:0] r_discard;
  logic [XLEN-1:0]  r_tag [DEPTH];
  logic [PTR_W-1:0] r_tag_wr;
  logic [PTR_W-1:0] r_tag_rd;

  logic             w_req;
  logic             w_fire;
  logic             w_rvalid;
  logic             w_push;
  logic             w_pop;
  logic             w_empty;
  logic             w_full;
  logic [CNT_W-1:0] w_count;
  fetch_entry_t     w_head;
  fetch_entry_t     w_entry;

  // Issue only when a slot is reserved for the response; never during a redirect
  always_comb begin
    w_req    = (rst != RST_ENABLE) && !ex_jump_flag_i &&
               ((SUM_W'(w_count) + SUM_W'(r_outstanding)) < SUM_W'(DEPTH));
    w_fire   = w_req && ibus.gnt;
    w_rvalid = ibus.rvalid && (r_outstanding != '0);
    w_push   = w_rvalid && (r_discard == '0) && !ex_jump_flag_i;
    w_pop    = !w_empty && !hold_i && !ex_jump_flag_i;
    w_entry.addr = r_tag[r_tag_rd];
    w_entry.inst = ibus.rdata;
  end

  assign ibus.req  = w_req;
  assign ibus.addr = r_pc;

  // After a redirect every fetch still in flight is stale
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      r_pc          <= RESET_PC;
      r_outstanding <= '0;
      r_discard     <= '0;
      r_tag_wr      <= '0;
      r_tag_rd      <= '0;
    end else begin
      if (ex_jump_flag_i)  r_pc <= ex_jump_addr_i;
      else if (w_fire)     r_pc <= next_pc(r_pc);

      r_outstanding <= r_outstanding + CNT_W'(w_fire) - CNT_W'(w_rvalid);

      if (ex_jump_flag_i)                     r_discard <= r_outstanding - CNT_W'(w_rvalid);
      else if (w_rvalid && r_discard != '0)   r_discard <= r_discard - CNT_W'(1);

      if (w_fire)   r_tag_wr <= r_tag_wr + PTR_W'(1);
      if (w_rvalid) r_tag_rd <= r_tag_rd + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_fire) r_tag[r_tag_wr] <= r_pc;
  end

  if_prefetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_entry (w_entry),
    .i_pop   (w_pop),
    .i_flush (ex_jump_flag_i),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign inst_valid_o = !w_empty;
  assign inst_o       = w_empty ? INST_NOP  : w_head.inst;
  assign inst_addr_o  = w_empty ? ZERO_WORD : w_head.addr;

  a_rvalid_without_request: assert property (
    @(posedge clk) disable iff (rst == RST_ENABLE) !(ibus.rvalid && r_outstanding == '0));

  a_fifo_no_overflow: assert property (
    @(posedge clk) disable iff (rst == RST_ENABLE) !(w_push && w_full && !w_pop));

endmodule

// File: tb/tb_if_prefetch.sv
// Randomized bench for if_prefetch against a queue-based reference model.
module tb_if_prefetch;
  import if_prefetch_pkg::*;

  localparam int unsigned  DEPTH    = 2;
  localparam logic [31:0]  RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        jump = 1'b0;
  logic [31:0] jaddr = '0;
  logic        hold = 1'b0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_addr;

  if_prefetch_if ibus ();

  if_prefetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .ex_jump_flag_i (jump),
    .ex_jump_addr_i (jaddr),
    .hold_i         (hold),
    .ibus           (ibus.master),
    .inst_valid_o   (inst_valid),
    .inst_o         (inst),
    .inst_addr_o    (inst_addr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[23:0], 8'h93} ^ 32'h5A00_0000;
  endfunction

  typedef struct {
    logic [31:0] addr;
    logic [31:0] inst;
  } q_ent_t;

  // Reference model: buffered words, in-flight fetches, and the bus responder
  q_ent_t      m_q[$];
  logic [31:0] m_out_addr[$];
  bit          m_out_stale[$];
  logic [31:0] m_pc;
  int          bus_ready[$];
  int          cyc;

  task automatic model_reset();
    m_q.delete();
    m_out_addr.delete();
    m_out_stale.delete();
    bus_ready.delete();
    m_pc = RESET_PC;
  endtask

  task automatic drive_idle();
    jump        = 1'b0;
    hold        = 1'b0;
    ibus.gnt    = 1'b0;
    ibus.rvalid = 1'b0;
    ibus.rdata  = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},        32'(ibus.req),   32'd0);
    check({tag, "_valid"},      32'(inst_valid), 32'd0);
    check({tag, "_inst"},       inst,            INST_NOP);
    check({tag, "_inst_addr"},  inst_addr,       32'd0);
  endtask

  // One clock: drive random inputs, compare outputs, advance the model
  task automatic step(input int p_jump, input int p_hold, input int p_gnt, input int max_delay);
    logic [31:0] r;
    logic        rv, exp_req, exp_valid, fire, push_new;
    logic [31:0] ret_addr;
    bit          ret_stale;

    @(negedge clk);
    cyc++;
    r        = $urandom;
    jump     = ($urandom_range(99) < p_jump);
    jaddr    = {20'h0, r[11:2], 2'b00};
    hold     = ($urandom_range(99) < p_hold);
    ibus.gnt = ($urandom_range(99) < p_gnt);
    rv       = (bus_ready.size() > 0) && (bus_ready[0] <= cyc);
    ibus.rvalid = rv;
    ibus.rdata  = rv ? mem_word(m_out_addr[0]) : $urandom;
    #1;

    exp_req   = !jump && ((m_q.size() + m_out_addr.size()) < DEPTH);
    exp_valid = (m_q.size() > 0);
    check("req", 32'(ibus.req), 32'(exp_req));
    if (exp_req) check("ibus_addr", ibus.addr, m_pc);
    check("inst_valid", 32'(inst_valid), 32'(exp_valid));
    check("inst",      inst,      exp_valid ? m_q[0].inst : INST_NOP);
    check("inst_addr", inst_addr, exp_valid ? m_q[0].addr : 32'd0);

    fire     = exp_req && ibus.gnt;
    push_new = 1'b0;
    ret_addr = '0;
    if (rv) begin
      ret_addr  = m_out_addr.pop_front();
      ret_stale = m_out_stale.pop_front();
      void'(bus_ready.pop_front());
      push_new  = !ret_stale && !jump;
    end
    if (jump) begin
      m_q.delete();
      foreach (m_out_stale[i]) m_out_stale[i] = 1'b1;
      m_pc = jaddr;
    end else begin
      if (exp_valid && !hold) void'(m_q.pop_front());
      if (push_new) m_q.push_back('{ret_addr, mem_word(ret_addr)});
    end
    if (fire) begin
      m_out_addr.push_back(m_pc);
      m_out_stale.push_back(1'b0);
      bus_ready.push_back(cyc + 1 + int'($urandom_range(max_delay)));
      m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic release_reset();
    drive_idle();
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    cyc = 0;
    drive_idle();
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("por");
    release_reset();

    repeat (400) step(3, 30, 70, 2);    // mixed streaming
    repeat (300) step(2, 85, 90, 1);    // decode mostly stalled
    repeat (300) step(25, 20, 90, 0);   // frequent redirects, fast bus
    repeat (300) step(10, 10, 100, 0);  // back-to-back grants, 1-cycle returns

    // Asynchronous reset in the middle of traffic
    for (int k = 0; k < 5; k++) begin
      repeat (40 + int'($urandom_range(20))) step(8, 25, 80, 2);
      #2;
      rst = 1'b0;
      #1;
      check_reset_outputs("midrst");
      drive_idle();
      @(negedge clk);
      release_reset();
    end

    repeat (200) step(5, 30, 75, 3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
